axis_pulse_framer: RTL and testbench

Converts the continuous, non-back-pressured ADC sample stream into tlast-terminated AXI4-Stream frames, one frame per detected pulse. A pulse is a rising threshold crossing. Each frame carries PRE_DEPTH samples preceding the trigger, then the trigger sample and the samples after it, FRAME_LENGTH beats in total. The block sits directly upstream of the frame summer, and its m interface feeds the summer's s interface.

---
 rtl/pulse_analyzer_pkg.sv | 25 ++
 rtl/axis_pulse_framer_if.sv | 12 +
 rtl/axis_pulse_framer_sample_delay_line.sv | 46 ++++
 rtl/axis_pulse_framer.sv | 182 ++++++++++++++++++
 tb/tb_axis_pulse_framer.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/pulse_analyzer_pkg.sv
// Shared types, sizing helpers and parameter-legality checks for the pulse framer.
package pulse_analyzer_pkg;

    // Framer control state: waiting for a pulse, or streaming a frame out.
    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_CAPTURE = 1'b1
    } framer_state_e;

    // Width of the beat counter; it indexes beats 0 .. frame_length-1.
    function automatic int beat_cnt_width(input int frame_length);
        return $clog2(frame_length);
    endfunction

    // The delay line wraps its pointer naturally, so its depth must be a power of two.
    function automatic bit pre_depth_legal(input int pre_depth);
        return (pre_depth >= 2) && ((pre_depth & (pre_depth - 1)) == 0);
    endfunction

    // A frame must hold at least the pre-trigger history plus the trigger sample.
    function automatic bit frame_length_legal(input int frame_length, input int pre_depth);
        return frame_length > pre_depth;
    endfunction

endpackage

// File: rtl/axis_pulse_framer_if.sv
// AXI4-Stream bundle used on both sides of the pulse framer.
interface axis_pulse_framer_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tlast;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/axis_pulse_framer_sample_delay_line.sv
// Circular sample buffer: the read port shows the slot about to be overwritten,
// i.e. the sample written DEPTH accepts ago.
module sample_delay_line #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      ptr_q;
    logic [PTR_W-1:0]      ptr_d;

    // Pointer advances once per write and wraps at DEPTH.
    always_comb begin
        ptr_d = ptr_q;
        if (wr_en_i) begin
            ptr_d = ptr_q + PTR_W'(1);
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Sample storage.
    // NOTE: storage has no reset; the fill counter upstream keeps stale slots from being framed.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[ptr_q] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[ptr_q];

endmodule

// File: rtl/axis_pulse_framer.sv
// Cuts one tlast-terminated frame out of a free-running sample stream for every
// rising threshold crossing, including PRE_DEPTH samples of pre-trigger history.
module axis_pulse_framer
    import pulse_analyzer_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int PRE_DEPTH    = 16,
    parameter int FRAME_LENGTH = 256,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   resetn,
    axis_pulse_framer_if.slave     s,
    input  logic [DATA_WIDTH-1:0]  threshold,
    axis_pulse_framer_if.master    m,
    output logic [COUNT_WIDTH-1:0] frame_count,
    output logic                   stream_overflow_err
);
    localparam int BEAT_W = beat_cnt_width(FRAME_LENGTH);
    localparam int FILL_W = $clog2(PRE_DEPTH) + 1;

    if (!pre_depth_legal(PRE_DEPTH)) begin : g_bad_pre_depth
        $error("axis_pulse_framer: PRE_DEPTH must be a power of two and at least 2");
    end
    if (!frame_length_legal(FRAME_LENGTH, PRE_DEPTH)) begin : g_bad_frame_length
        $error("axis_pulse_framer: FRAME_LENGTH must exceed PRE_DEPTH");
    end

    framer_state_e           state_q, state_d;
    logic [FILL_W-1:0]       fill_q, fill_d;
    logic [DATA_WIDTH-1:0]   prev_q, prev_d;
    logic [BEAT_W-1:0]       beat_cnt_q, beat_cnt_d;
    logic                    m_tvalid_q, m_tvalid_d;
    logic [DATA_WIDTH-1:0]   m_tdata_q, m_tdata_d;
    logic                    m_tlast_q, m_tlast_d;
    logic [COUNT_WIDTH-1:0]  frame_count_q, frame_count_d;
    logic                    overflow_q, overflow_d;

    logic                    accept;
    logic                    primed;
    logic                    crossing;
    logic                    beat_is_last;
    logic                    emit;
    logic                    emit_last;
    logic                    start_frame;
    logic [DATA_WIDTH-1:0]   line_rd_data;
    logic                    unused_s_tlast;

    // The ADC source is unframed; its tlast carries no information.
    assign unused_s_tlast = s.tlast;
    assign s.tready       = 1'b1;
    assign accept         = s.tvalid;

    sample_delay_line #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (PRE_DEPTH)
    ) u_delay_line (
        .clk       (clk),
        .resetn    (resetn),
        .wr_en_i   (accept),
        .wr_data_i (s.tdata),
        .rd_data_o (line_rd_data)
    );

    assign primed       = (fill_q == FILL_W'(PRE_DEPTH));
    assign crossing     = accept && primed
                          && ($signed(prev_q)  <  $signed(threshold))
                          && ($signed(s.tdata) >= $signed(threshold));
    assign beat_is_last = (beat_cnt_q == BEAT_W'(FRAME_LENGTH - 1));

    // State register.
    // NOTE: sequential blocks use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a crossing opens a frame, the accept carrying the last beat closes it.
    // NOTE: each combinational output is defaulted first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (crossing)               state_d = ST_CAPTURE;
            ST_CAPTURE: if (accept && beat_is_last) state_d = ST_IDLE;
            default:                                state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: which accepts produce a beat, and which beat closes the frame.
    always_comb begin
        emit        = 1'b0;
        emit_last   = 1'b0;
        start_frame = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (crossing) begin
                    emit        = 1'b1;
                    start_frame = 1'b1;
                end
            end
            ST_CAPTURE: begin
                if (accept) begin
                    emit      = 1'b1;
                    emit_last = beat_is_last;
                end
            end
            default: ;
        endcase
    end

    // Datapath next values: priming, history, beat counting and the output register.
    always_comb begin
        fill_d        = fill_q;
        prev_d        = prev_q;
        beat_cnt_d    = beat_cnt_q;
        m_tvalid_d    = m_tvalid_q;
        m_tdata_d     = m_tdata_q;
        m_tlast_d     = m_tlast_q;
        frame_count_d = frame_count_q;
        overflow_d    = overflow_q;

        if (accept) begin
            prev_d = s.tdata;
            if (!primed) begin
                fill_d = fill_q + FILL_W'(1);
            end
        end

        if (start_frame) begin
            beat_cnt_d    = BEAT_W'(1);
            frame_count_d = frame_count_q + COUNT_WIDTH'(1);
        end else if (emit) begin
            beat_cnt_d = emit_last ? '0 : beat_cnt_q + BEAT_W'(1);
        end

        // A load over an untaken beat drops it but keeps the frame's beat count intact.
        if (emit) begin
            m_tvalid_d = 1'b1;
            m_tdata_d  = line_rd_data;
            m_tlast_d  = emit_last;
            if (m_tvalid_q && !m.tready) begin
                overflow_d = 1'b1;
            end
        end else if (m.tready) begin
            m_tvalid_d = 1'b0;
            m_tlast_d  = 1'b0;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            fill_q        <= '0;
            prev_q        <= '0;
            beat_cnt_q    <= '0;
            m_tvalid_q    <= 1'b0;
            m_tdata_q     <= '0;
            m_tlast_q     <= 1'b0;
            frame_count_q <= '0;
            overflow_q    <= 1'b0;
        end else begin
            fill_q        <= fill_d;
            prev_q        <= prev_d;
            beat_cnt_q    <= beat_cnt_d;
            m_tvalid_q    <= m_tvalid_d;
            m_tdata_q     <= m_tdata_d;
            m_tlast_q     <= m_tlast_d;
            frame_count_q <= frame_count_d;
            overflow_q    <= overflow_d;
        end
    end

    assign m.tvalid            = m_tvalid_q;
    assign m.tdata             = m_tdata_q;
    assign m.tlast             = m_tlast_q;
    assign frame_count         = frame_count_q;
    assign stream_overflow_err = overflow_q;

endmodule

// File: tb/tb_axis_pulse_framer.sv
// Directed bench for axis_pulse_framer: stimulus pushes hand-computed beats into a
// scoreboard queue, a monitor pops and compares every transferred output beat.
module tb_axis_pulse_framer;

    localparam int DW = 16;
    localparam int PD = 4;
    localparam int FL = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [DW-1:0] threshold;
    logic [CW-1:0] frame_count;
    logic          stream_overflow_err;

    axis_pulse_framer_if #(.DATA_WIDTH(DW)) s_if ();
    axis_pulse_framer_if #(.DATA_WIDTH(DW)) m_if ();

    axis_pulse_framer #(
        .DATA_WIDTH   (DW),
        .PRE_DEPTH    (PD),
        .FRAME_LENGTH (FL),
        .COUNT_WIDTH  (CW)
    ) dut (
        .clk                 (clk),
        .resetn              (resetn),
        .s                   (s_if),
        .threshold           (threshold),
        .m                   (m_if),
        .frame_count         (frame_count),
        .stream_overflow_err (stream_overflow_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t exp_q[$];
    beat_t got_beat;
    int    total = 0;
    int    bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic push_beat(input int value, input logic last);
        beat_t b;
        b.data = DW'(value);
        b.last = last;
        exp_q.push_back(b);
    endtask

    // One accept of sample x, with m_tready held at rdy during the cycle before the edge.
    task automatic drive(input int x, input logic rdy);
        s_if.tvalid = 1'b1;
        s_if.tdata  = DW'(x);
        m_if.tready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn      = 1'b0;
        s_if.tvalid = 1'b0;
        m_if.tready = 1'b1;
        threshold   = DW'(100);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    // Scoreboard monitor: each transferred beat must match the head of the queue.
    always @(negedge clk) begin
        if (m_if.tvalid && m_if.tready) begin
            check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                got_beat = exp_q.pop_front();
                check("beat_tdata", 32'(m_if.tdata), 32'(got_beat.data));
                check("beat_tlast", 32'(m_if.tlast), 32'(got_beat.last));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b1;
        threshold   = DW'(100);

        // Reset state.
        do_reset();
        check("rst_tvalid", 32'(m_if.tvalid), 32'd0);
        check("rst_tdata", 32'(m_if.tdata), 32'd0);
        check("rst_tlast", 32'(m_if.tlast), 32'd0);
        check("rst_frame_count", 32'(frame_count), 32'd0);
        check("rst_overflow", 32'(stream_overflow_err), 32'd0);
        check("rst_s_tready", 32'(s_if.tready), 32'd1);

        // Ramp 10k: trigger at k=10, frame x[6..13].
        for (int i = 0; i < FL; i++) push_beat(60 + 10 * i, i == FL - 1);
        for (int k = 0; k < 20; k++) begin
            drive(10 * k, 1'b1);
            if (k == 9) check("ramp_no_early_beat", 32'(m_if.tvalid), 32'd0);
            if (k == 10) begin
                check("ramp_latency_tvalid", 32'(m_if.tvalid), 32'd1);
                check("ramp_first_tdata", 32'(m_if.tdata), 32'd60);
                check("ramp_frame_count_edge", 32'(frame_count), 32'd1);
            end
        end
        s_if.tvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("ramp_frame_count", 32'(frame_count), 32'd1);
        check("ramp_drained", 32'(exp_q.size()), 32'd0);

        // Unprimed crossing at k=2 ignored; trigger at k=7, frame x[3..10].
        do_reset();
        push_beat(0, 1'b0); push_beat(0, 1'b0); push_beat(0, 1'b0); push_beat(0, 1'b0);
        push_beat(150, 1'b0); push_beat(1, 1'b0); push_beat(2, 1'b0); push_beat(3, 1'b1);
        begin
            int seq2[16] = '{0, 0, 150, 0, 0, 0, 0, 150, 1, 2, 3, 0, 0, 0, 0, 0};
            for (int k = 0; k < 16; k++) begin
                drive(seq2[k], 1'b1);
                if (k == 2) check("unprimed_no_trigger", 32'(frame_count), 32'd0);
            end
        end
        check("unprimed_frame_count", 32'(frame_count), 32'd1);
        check("unprimed_drained", 32'(exp_q.size()), 32'd0);

        // Crossings at 2,5,8,11 and 13: 8,11 fall inside frame 1, 13 is back-to-back.
        do_reset();
        push_beat(0, 1'b0); push_beat(150, 1'b0); push_beat(0, 1'b0); push_beat(0, 1'b0);
        push_beat(150, 1'b0); push_beat(0, 1'b0); push_beat(0, 1'b0); push_beat(150, 1'b1);
        push_beat(0, 1'b0); push_beat(0, 1'b0); push_beat(150, 1'b0); push_beat(0, 1'b0);
        push_beat(150, 1'b0); push_beat(0, 1'b0); push_beat(0, 1'b0); push_beat(0, 1'b1);
        for (int k = 0; k < 23; k++) begin
            drive((k == 2 || k == 5 || k == 8 || k == 11 || k == 13) ? 150 : 0, 1'b1);
            if (k == 11) check("capture_ignores_cross", 32'(frame_count), 32'd1);
            if (k == 12) check("b2b_tlast_beat", 32'(m_if.tlast), 32'd1);
            if (k == 13) begin
                check("b2b_no_idle_tvalid", 32'(m_if.tvalid), 32'd1);
                check("b2b_beat0_tlast", 32'(m_if.tlast), 32'd0);
                check("b2b_frame_count", 32'(frame_count), 32'd2);
            end
        end
        check("b2b_drained", 32'(exp_q.size()), 32'd0);

        // Signed compares with a negative threshold, then non-crossing patterns.
        do_reset();
        threshold = DW'(-50);
        for (int i = 0; i < 4; i++) push_beat(-100, 1'b0);
        push_beat(-50, 1'b0); push_beat(-100, 1'b0); push_beat(-100, 1'b0); push_beat(-100, 1'b1);
        for (int k = 0; k < 6; k++) drive(-100, 1'b1);
        drive(-50, 1'b1);
        check("signed_trigger", 32'(frame_count), 32'd1);
        for (int k = 7; k < 14; k++) drive(-100, 1'b1);
        drive(-100, 1'b1);
        drive(32'h9C40, 1'b1);
        check("signed_trunc_no_trigger", 32'(frame_count), 32'd1);
        threshold = DW'(100);
        drive(50, 1'b1);
        drive(-100, 1'b1);
        drive(0, 1'b1);
        drive(0, 1'b1);
        check("signed_neg_no_trigger", 32'(frame_count), 32'd1);
        check("signed_drained", 32'(exp_q.size()), 32'd0);

        // Back-pressure mid-frame: beats 80 and 90 are overwritten.
        do_reset();
        push_beat(60, 1'b0); push_beat(70, 1'b0); push_beat(100, 1'b0);
        push_beat(110, 1'b0); push_beat(120, 1'b0); push_beat(130, 1'b1);
        for (int k = 0; k < 20; k++) begin
            drive(10 * k, !(k == 13 || k == 14));
            if (k == 12) check("ovf_not_yet", 32'(stream_overflow_err), 32'd0);
            if (k == 13) check("ovf_set", 32'(stream_overflow_err), 32'd1);
        end
        check("ovf_sticky", 32'(stream_overflow_err), 32'd1);
        check("ovf_drained", 32'(exp_q.size()), 32'd0);

        // Reset while beat 3 is presented: frame abandoned, line must re-prime.
        do_reset();
        for (int i = 0; i < 4; i++) push_beat(60 + 10 * i, 1'b0);
        for (int k = 0; k < 14; k++) drive(10 * k, 1'b1);
        resetn      = 1'b0;
        s_if.tdata  = DW'(140);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        check("midrst_tvalid", 32'(m_if.tvalid), 32'd0);
        check("midrst_frame_count", 32'(frame_count), 32'd0);
        check("midrst_overflow", 32'(stream_overflow_err), 32'd0);
        begin
            int seq6[8] = '{0, 150, 0, 0, 0, 0, 0, 0};
            for (int k = 0; k < 8; k++) drive(seq6[k], 1'b1);
        end
        check("midrst_reprime_no_trigger", 32'(frame_count), 32'd0);
        check("midrst_idle_tvalid", 32'(m_if.tvalid), 32'd0);
        check("midrst_drained", 32'(exp_q.size()), 32'd0);

        s_if.tvalid = 1'b0;
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
